// File: rtl/msg_tx_pkg.sv
// Shared definitions for the status message transmitter: ASCII codes, request
// codes, queue entry layout and the frame byte table.
package msg_tx_pkg;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_QM   = 8'h3F;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_I    = 8'h49;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_N    = 8'h4E;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_U    = 8'h55;

    localparam logic [1:0] UNIT_E       = 2'd0;
    localparam logic [1:0] UNIT_C       = 2'd1;
    localparam logic [1:0] UNIT_R       = 2'd2;
    localparam logic [1:0] UNIT_ILLEGAL = 2'd3;

    localparam int ENTRY_W = 6;

    typedef enum logic [1:0] {
        REQ_FIM = 2'd0,
        REQ_BPM = 2'd1,
        REQ_BDM = 2'd2,
        REQ_END = 2'd3
    } req_type_e;

    typedef struct packed {
        req_type_e  rtype;
        logic [1:0] unit;
        logic [1:0] block;
    } req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] unit_char(input logic [1:0] unit);
        case (unit)
            UNIT_E:  return ASCII_E;
            UNIT_C:  return ASCII_C;
            UNIT_R:  return ASCII_R;
            default: return ASCII_QM;
        endcase
    endfunction

    // Any index past the end of a frame maps to the terminator.
    function automatic logic [7:0] frame_byte(input req_entry_t e, input logic [3:0] idx);
        logic [7:0] b;
        b = ASCII_HASH;
        case (e.rtype)
            REQ_FIM, REQ_BDM: begin
                case (idx)
                    4'd0:    b = (e.rtype == REQ_FIM) ? ASCII_F : ASCII_B;
                    4'd1:    b = (e.rtype == REQ_FIM) ? ASCII_I : ASCII_D;
                    4'd2:    b = ASCII_M;
                    4'd3:    b = ASCII_DASH;
                    4'd4:    b = unit_char(e.unit);
                    4'd5:    b = ASCII_DASH;
                    default: b = ASCII_HASH;
                endcase
            end
            REQ_BPM: begin
                case (idx)
                    4'd0:    b = ASCII_B;
                    4'd1:    b = ASCII_P;
                    4'd2:    b = ASCII_M;
                    4'd3:    b = ASCII_DASH;
                    4'd4:    b = ASCII_S;
                    4'd5:    b = ASCII_U;
                    4'd6:    b = ASCII_DASH;
                    4'd7:    b = ASCII_B;
                    4'd8:    b = ASCII_ONE + {6'd0, e.block};
                    4'd9:    b = ASCII_DASH;
                    default: b = ASCII_HASH;
                endcase
            end
            REQ_END: begin
                case (idx)
                    4'd0:    b = ASCII_E;
                    4'd1:    b = ASCII_N;
                    4'd2:    b = ASCII_D;
                    4'd3:    b = ASCII_DASH;
                    default: b = ASCII_HASH;
                endcase
            end
            default: b = ASCII_HASH;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/msg_tx_fifo.sv
// Request queue for msg_tx: synchronous FIFO of 6-bit entries with a
// combinational read port; pointers wrap modulo the depth.
module msg_tx_fifo
    import msg_tx_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = (FIFO_DEPTH_LOG2)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    logic [ENTRY_W-1:0]         r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       w_push;
    logic                       w_pop;

    assign full   = (r_count == CNT_FULL);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/msg_tx.sv
// Status message transmitter: queues event requests and streams each one as a
// '#'-terminated ASCII frame into uart_tx over a start/done byte handshake.
module msg_tx
    import msg_tx_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int GAP_CYCLES      = 4340,
    parameter int TX_TIMEOUT      = 500000
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_type,
    input  logic [1:0] req_unit,
    input  logic [1:0] req_block,
    output logic       req_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    output logic       msg_active,
    output logic       msg_sent,
    output logic       err_drop,
    output logic       err_timeout
);
    localparam logic [18:0] TIMEOUT_LAST = 19'(TX_TIMEOUT - 1);
    // IDLE and LOAD account for two of the idle cycles before the next tx_start.
    localparam logic [18:0] GAP_LAST     = 19'((GAP_CYCLES > 3) ? (GAP_CYCLES - 3) : 0);

    tx_state_e          r_state;
    req_entry_t         r_entry;
    logic [3:0]         r_idx;
    logic [18:0]        r_cnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_msg_active;
    logic               r_msg_sent;
    logic               r_err_drop;
    logic               r_err_timeout;

    logic               w_full;
    logic               w_empty;
    logic               w_illegal;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;

    assign w_illegal = ((req_type == REQ_FIM) || (req_type == REQ_BDM)) && (req_unit == UNIT_ILLEGAL);
    assign w_push    = req_valid && !w_full && !w_illegal;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_din     = {req_type, req_unit, req_block};

    assign req_ready   = !w_full;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign msg_active  = r_msg_active;
    assign msg_sent    = r_msg_sent;
    assign err_drop    = r_err_drop;
    assign err_timeout = r_err_timeout;

    msg_tx_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_50M),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Rejected request strobe: queue full or an illegal unit on FIM/BDM.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_err_drop <= 1'b0;
        end else begin
            r_err_drop <= req_valid && (w_full || w_illegal);
        end
    end

    // Frame sequencer; follow-on bytes launch straight from WAIT so tx_start trails tx_done by one cycle.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_entry       <= '0;
            r_idx         <= 4'd0;
            r_cnt         <= 19'd0;
            r_tx_data     <= 8'd0;
            r_tx_start    <= 1'b0;
            r_msg_active  <= 1'b0;
            r_msg_sent    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_msg_sent    <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_entry <= req_entry_t'(w_dout);
                        r_idx   <= 4'd0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_tx_data    <= frame_byte(r_entry, r_idx);
                    r_tx_start   <= 1'b1;
                    r_msg_active <= 1'b1;
                    r_cnt        <= 19'd0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done && !r_tx_start) begin
                        r_cnt <= 19'd0;
                        if (r_tx_data == ASCII_HASH) begin
                            r_msg_sent   <= 1'b1;
                            r_msg_active <= 1'b0;
                            r_state      <= ST_GAP;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_tx_data  <= frame_byte(r_entry, r_idx + 4'd1);
                            r_tx_start <= 1'b1;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_msg_active  <= 1'b0;
                        r_cnt         <= 19'd0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 19'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 19'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 19'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tx.sv
// Randomized bench for msg_tx: frames are predicted as text strings from the
// request fields and compared byte by byte against what reaches the UART model.
module tb_msg_tx;
    localparam int GAP      = 40;
    localparam int TMO      = 100;
    localparam int UART_LAT = 10;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_type;
    logic [1:0] req_unit;
    logic [1:0] req_block;
    logic       req_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic       msg_active;
    logic       msg_sent;
    logic       err_drop;
    logic       err_timeout;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    string exp_frames[$];
    string cur_frame = "";
    int    cur_pos = 0;
    int    n_starts = 0, n_sent = 0, n_drop = 0, n_tout = 0;
    int    last_done_cyc = 0, last_start_cyc = 0, hash_done_cyc = 0;
    int    frame_start_cyc = 0, gap_seen = 0, tout_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    int    uart_seen = 0;
    int    withhold_at = -1;

    msg_tx #(
        .FIFO_DEPTH_LOG2(2),
        .GAP_CYCLES(GAP),
        .TX_TIMEOUT(TMO)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_type    (req_type),
        .req_unit    (req_unit),
        .req_block   (req_block),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .msg_active  (msg_active),
        .msg_sent    (msg_sent),
        .err_drop    (err_drop),
        .err_timeout (err_timeout)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string frame_text(input int t, input int u, input int b);
        string units;
        units = "ECR";
        case (t)
            0:       return $sformatf("FIM-%s-#", units.substr(u, u));
            1:       return $sformatf("BPM-SU-B%0d-#", b + 1);
            2:       return $sformatf("BDM-%s-#", units.substr(u, u));
            default: return "END-#";
        endcase
    endfunction

    function automatic bit legal(input int t, input int u);
        return !(((t == 0) || (t == 2)) && (u == 3));
    endfunction

    // UART byte transmitter model: tx_done UART_LAT cycles after each tx_start.
    initial begin : uart_model
        int cnt;
        cnt = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk_50M);
            #2;
            tx_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
                if (tx_start) begin
                    uart_seen++;
                    if (uart_seen != withhold_at) cnt = UART_LAT;
                end
            end
        end
    end

    // Output monitor and byte scoreboard, sampled on the falling edge.
    initial begin : monitor
        forever begin
            @(negedge clk_50M);
            if (!reset) begin
                if (tx_done) begin
                    last_done_cyc = cyc;
                    if (last_byte == 8'h23) hash_done_cyc = cyc;
                end
                if (tx_start) begin
                    n_starts++;
                    check_eq("active_with_start", msg_active, 1'b1);
                    if (cur_pos == 0) begin
                        check_eq("frame_expected", exp_frames.size() > 0, 1);
                        if (exp_frames.size() > 0) cur_frame = exp_frames.pop_front();
                        else cur_frame = "";
                        frame_start_cyc = cyc;
                        gap_seen = cyc - hash_done_cyc - 1;
                    end else begin
                        check_eq("byte_after_done", cyc - last_done_cyc, 1);
                    end
                    if (cur_pos < cur_frame.len()) begin
                        check_eq("tx_byte", tx_data, cur_frame[cur_pos]);
                        cur_pos++;
                        if (cur_pos == cur_frame.len()) cur_pos = 0;
                    end
                    last_byte = tx_data;
                    last_start_cyc = cyc;
                end
                if (msg_sent) n_sent++;
                if (err_drop) n_drop++;
                if (err_timeout) begin
                    n_tout++;
                    tout_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #2;
    endtask

    task automatic push_req(input int t, input int u, input int b, input logic exp_rdy);
        req_type  = 2'(t);
        req_unit  = 2'(u);
        req_block = 2'(b);
        req_valid = 1'b1;
        @(negedge clk_50M);
        check_eq("req_ready", req_ready, exp_rdy);
        if (exp_rdy && legal(t, u)) exp_frames.push_back(frame_text(t, u, b));
        @(posedge clk_50M);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_sent(input int target);
        int budget;
        budget = 3000;
        while ((n_sent < target) && (budget > 0)) begin
            tick(1);
            budget--;
        end
        check_eq("msg_sent_count", n_sent, target);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_tx_start"}, tx_start, 1'b0);
        check_eq({tag, "_tx_data"}, tx_data, 8'h00);
        check_eq({tag, "_msg_active"}, msg_active, 1'b0);
        check_eq({tag, "_msg_sent"}, msg_sent, 1'b0);
        check_eq({tag, "_err_drop"}, err_drop, 1'b0);
        check_eq({tag, "_err_timeout"}, err_timeout, 1'b0);
        check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin : stimulus
        int t, u, b, acc, tgt, d0, s0, t0, budget;
        reset = 1'b1;
        req_valid = 1'b0;
        req_type = 2'd0;
        req_unit = 2'd0;
        req_block = 2'd0;
        tick(3);
        check_quiet_outputs("reset");
        reset = 1'b0;
        tick(2);

        // FIM unit E, with first-byte latency
        acc = cyc + 1;
        tgt = n_sent + 1;
        push_req(0, 0, 0, 1'b1);
        wait_sent(tgt);
        check_eq("first_latency", frame_start_cyc - acc, 2);
        check_eq("active_after_frame", msg_active, 1'b0);
        tick(GAP + 4);

        // random single frames from idle
        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(0, 3);
            u = $urandom_range(0, 2);
            b = $urandom_range(0, 3);
            acc = cyc + 1;
            tgt = n_sent + 1;
            push_req(t, u, b, 1'b1);
            wait_sent(tgt);
            check_eq("rand_latency", frame_start_cyc - acc, 2);
            tick(GAP + 4);
        end

        // BPM block 2 followed by queued END: inter-frame gap
        tgt = n_sent + 2;
        push_req(1, 0, 2, 1'b1);
        push_req(3, 0, 0, 1'b1);
        wait_sent(tgt);
        check_eq("gap_cycles", gap_seen, GAP);
        tick(GAP + 4);

        // five back-to-back requests while a frame is in flight
        d0 = n_drop;
        tgt = n_sent + 5;
        push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        budget = 20;
        while (!msg_active && (budget > 0)) begin
            tick(1);
            budget--;
        end
        check_eq("busy_before_burst", msg_active, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), (i < 4) ? 1'b1 : 1'b0);
        end
        tick(2);
        check_eq("drop_on_full", n_drop - d0, 1);
        wait_sent(tgt);
        tick(GAP + 4);

        // illegal unit on FIM and BDM
        d0 = n_drop;
        s0 = n_starts;
        push_req(0, 3, $urandom_range(0, 3), 1'b1);
        push_req(2, 3, $urandom_range(0, 3), 1'b1);
        tick(1);
        check_eq("drop_illegal", n_drop - d0, 2);
        tick(10);
        check_eq("no_start_illegal", n_starts - s0, 0);
        acc = cyc + 1;
        tgt = n_sent + 1;
        push_req(3, 0, 0, 1'b1);
        wait_sent(tgt);
        check_eq("latency_after_illegal", frame_start_cyc - acc, 2);
        tick(GAP + 4);

        // tx_done withheld on the third byte
        t0 = n_tout;
        tgt = n_sent + 1;
        withhold_at = uart_seen + 3;
        push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        budget = 400;
        while ((n_tout == t0) && (budget > 0)) begin
            tick(1);
            budget--;
        end
        check_eq("timeout_seen", n_tout - t0, 1);
        check_eq("timeout_cycles", tout_cyc - last_start_cyc, TMO);
        check_eq("active_after_timeout", msg_active, 1'b0);
        cur_pos = 0;
        withhold_at = -1;
        wait_sent(tgt);
        tick(GAP + 4);

        // reset in the middle of a frame with another one queued
        s0 = n_starts;
        push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        push_req($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
        budget = 200;
        while ((n_starts - s0 < 4) && (budget > 0)) begin
            tick(1);
            budget--;
        end
        check_eq("reached_byte4", n_starts - s0, 4);
        reset = 1'b1;
        #1;
        check_quiet_outputs("midreset");
        exp_frames.delete();
        cur_pos = 0;
        tick(3);
        reset = 1'b0;
        s0 = n_starts;
        tick(20);
        check_eq("no_stale_bytes", n_starts - s0, 0);
        acc = cyc + 1;
        tgt = n_sent + 1;
        push_req(3, 0, 0, 1'b1);
        wait_sent(tgt);
        check_eq("latency_after_reset", frame_start_cyc - acc, 2);
        tick(GAP + 4);

        check_eq("frames_left", exp_frames.size(), 0);
        check_eq("frame_pos", cur_pos, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
